// File: rtl/riscv_pkg.sv
// Shared RV32I datapath definitions.
//   XLEN      : datapath / immediate width (only 32 supported)
//   IMM_W     : width of the raw immediate field fed from decode
//   imm_src_t : immediate format select codes; 3'b110 and 3'b111 are
//               intentionally left unassigned and are reported as illegal
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int IMM_W = 12;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100,
        IMM_Z = 3'b101
    } imm_src_t;

    // True for the two reserved select codes.
    function automatic logic imm_src_illegal(input logic [2:0] src);
        return (src == 3'b110) || (src == 3'b111);
    endfunction

endpackage

// File: rtl/extend_unit_if.sv
// Request/result bundle between decode and the immediate generator.
//   in_valid  : qualifies ImmSrc/ext/instr this cycle
//   ImmSrc    : immediate format select
//   ext       : raw 12-bit immediate field (I and Z formats)
//   instr     : full instruction word (S, B, U and J formats)
//   ImmExt    : registered 32-bit immediate
//   out_valid : ImmExt was loaded from a valid request last cycle
//   illegal   : last accepted ImmSrc was a reserved code
// Modports: master drives requests and observes results, slave is the
// immediate generator.
interface extend_unit_if;
    import riscv_pkg::*;

    logic             in_valid;
    logic [2:0]       ImmSrc;
    logic [IMM_W-1:0] ext;
    logic [31:0]      instr;
    logic [XLEN-1:0]  ImmExt;
    logic             out_valid;
    logic             illegal;

    modport master (
        output in_valid, ImmSrc, ext, instr,
        input  ImmExt, out_valid, illegal
    );

    modport slave (
        input  in_valid, ImmSrc, ext, instr,
        output ImmExt, out_valid, illegal
    );

endinterface

// File: rtl/extend_unit_imm_decode.sv
// Combinational immediate builder (module imm_decode).
//   imm_src : format select
//   ext     : raw 12-bit field, read only for I and Z
//   instr   : instruction word, read only for S, B, U and J
//   imm     : assembled 32-bit immediate (0 for reserved selects)
//   illegal : select is a reserved code
// Every arm touches only the input its format needs, so X on the
// unused operand cannot leak into the result.
module imm_decode
    import riscv_pkg::*;
(
    input  logic [2:0]       imm_src,
    input  logic [IMM_W-1:0] ext,
    input  logic [31:0]      instr,
    output logic [XLEN-1:0]  imm,
    output logic             illegal
);

    // Opcode field never contributes to any immediate.
    logic unused_opcode;
    assign unused_opcode = &{1'b0, instr[6:0]};

    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (imm_src)
            IMM_I: imm = {{20{ext[11]}}, ext};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'h000};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            IMM_Z: imm = {20'h0, ext};
            default: begin
                imm     = '0;
                illegal = imm_src_illegal(imm_src);
            end
        endcase
    end

endmodule

// File: rtl/extend_unit.sv
// RV32I immediate generator with a single output register stage.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all outputs
//   bus   : request/result bundle (slave side)
// A valid request loads ImmExt and illegal on the next edge and raises
// out_valid for exactly that cycle; idle cycles hold ImmExt/illegal.
module extend_unit
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    extend_unit_if.slave bus
);

    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;

    imm_decode u_imm_decode (
        .imm_src (bus.ImmSrc),
        .ext     (bus.ext),
        .instr   (bus.instr),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    logic [XLEN-1:0] imm_q;
    logic            valid_q;
    logic            illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_q     <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                imm_q     <= dec_imm;
                illegal_q <= dec_illegal;
            end
        end
    end

    assign bus.ImmExt    = imm_q;
    assign bus.out_valid = valid_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_extend_unit.sv
module tb_extend_unit;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   chk_on = 0;

    extend_unit_if bus ();

    extend_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value of each format computed arithmetically from field
    // weights, then wrapped to the signed range of the format width.
    function automatic logic [31:0] model(input logic [2:0] s,
                                          input logic [11:0] e,
                                          input logic [31:0] i);
        int v;
        logic [31:0] r;
        v = 0;
        r = 32'h0;
        case (s)
            3'd0: begin
                v = int'(e);
                if (v >= 2048) v = v - 4096;
                r = v;
            end
            3'd1: begin
                v = int'(i[31:25]) * 32 + int'(i[11:7]);
                if (v >= 2048) v = v - 4096;
                r = v;
            end
            3'd2: begin
                v = int'(i[31]) * 4096 + int'(i[7]) * 2048
                  + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
                if (v >= 4096) v = v - 8192;
                r = v;
            end
            3'd3: r = i - (i % 32'd4096);
            3'd4: begin
                v = int'(i[31]) * 1048576 + int'(i[19:12]) * 4096
                  + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
                if (v >= 1048576) v = v - 2097152;
                r = v;
            end
            3'd5: r = int'(e);
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected register state, updated on the same events as the DUT.
    logic [31:0] exp_imm;
    logic        exp_valid;
    logic        exp_ill;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_imm   = 32'h0;
            exp_valid = 1'b0;
            exp_ill   = 1'b0;
        end else begin
            exp_valid = bus.in_valid;
            if (bus.in_valid === 1'b1) begin
                exp_imm = model(bus.ImmSrc, bus.ext, bus.instr);
                exp_ill = (bus.ImmSrc >= 3'd6);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_imm",     bus.ImmExt,            exp_imm);
            chk("cyc_valid",   {31'h0, bus.out_valid}, {31'h0, exp_valid});
            chk("cyc_illegal", {31'h0, bus.illegal},   {31'h0, exp_ill});
        end
    end

    // Present a request just after an edge, then advance to just after the
    // edge that registers it.
    task automatic step(input logic v, input logic [2:0] s,
                        input logic [11:0] e, input logic [31:0] i);
        bus.in_valid = v;
        bus.ImmSrc   = s;
        bus.ext      = e;
        bus.instr    = i;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [31:0] imm,
                           input logic v, input logic ill);
        chk({name, "_imm"},     bus.ImmExt,            imm);
        chk({name, "_valid"},   {31'h0, bus.out_valid}, {31'h0, v});
        chk({name, "_illegal"}, {31'h0, bus.illegal},   {31'h0, ill});
    endtask

    initial begin
        logic [11:0] xe;
        logic [31:0] xi;
        xe = 'x;
        xi = 'x;

        // Pin the model to hand-derived values.
        chk("model_I_neg", model(3'd0, 12'hABC, 32'h0), 32'hFFFFFABC);
        chk("model_I_pos", model(3'd0, 12'h7FF, 32'h0), 32'h000007FF);
        chk("model_Z",     model(3'd5, 12'hABC, 32'h0), 32'h00000ABC);
        chk("model_S",     model(3'd1, 12'h0, 32'hFE000F80), 32'hFFFFFFFF);
        chk("model_B",     model(3'd2, 12'h0, 32'h00000080), 32'h00000800);
        chk("model_U",     model(3'd3, 12'h0, 32'h12345678), 32'h12345000);
        chk("model_J",     model(3'd4, 12'h0, 32'h80000000), 32'hFFF00000);
        chk("model_J_pos", model(3'd4, 12'h0, 32'h7FE00000), 32'h000007FE);

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.ImmSrc   = 3'd0;
        bus.ext      = 12'h0;
        bus.instr    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 32'h0, 1'b0, 1'b0);
        rst_n  = 1'b1;
        chk_on = 1;

        step(1'b1, 3'd0, 12'hABC, xi);          chk_out("I_neg", 32'hFFFFFABC, 1'b1, 1'b0);
        step(1'b1, 3'd0, 12'h7FF, xi);          chk_out("I_pos", 32'h000007FF, 1'b1, 1'b0);
        step(1'b1, 3'd5, 12'hABC, xi);          chk_out("Z",     32'h00000ABC, 1'b1, 1'b0);
        step(1'b1, 3'd1, xe, 32'hFE000F80);     chk_out("S",     32'hFFFFFFFF, 1'b1, 1'b0);
        step(1'b1, 3'd2, xe, 32'h00000080);     chk_out("B",     32'h00000800, 1'b1, 1'b0);
        step(1'b1, 3'd3, xe, 32'h12345000);     chk_out("U",     32'h12345000, 1'b1, 1'b0);
        step(1'b1, 3'd4, xe, 32'h80000000);     chk_out("J",     32'hFFF00000, 1'b1, 1'b0);
        step(1'b1, 3'd7, 12'h123, 32'hFFFFFFFF); chk_out("ill7", 32'h0, 1'b1, 1'b1);
        step(1'b0, 3'd1, 12'h0, 32'h0);         chk_out("idle_ill", 32'h0, 1'b0, 1'b1);
        step(1'b1, 3'd0, 12'h005, xi);          chk_out("clr_ill", 32'h00000005, 1'b1, 1'b0);
        step(1'b1, 3'd6, 12'hFFF, 32'h0);       chk_out("ill6", 32'h0, 1'b1, 1'b1);
        step(1'b1, 3'd3, xe, 32'hABCDE123);     chk_out("U2", 32'hABCDE000, 1'b1, 1'b0);
        step(1'b0, 3'd0, 12'h0, 32'h0);         chk_out("hold", 32'hABCDE000, 1'b0, 1'b0);

        // Load, then pull reset between edges.
        step(1'b1, 3'd7, 12'h0, 32'h0);         chk_out("pre_rst", 32'h0, 1'b1, 1'b1);
        bus.in_valid = 1'b1;
        bus.ImmSrc   = 3'd0;
        bus.ext      = 12'hFFF;
        @(posedge clk);
        #1;
        chk_out("pre_rst2", 32'hFFFFFFFF, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 32'h0, 1'b0, 1'b0);
        #5 rst_n = 1'b1;
        step(1'b1, 3'd0, 12'h001, xi);          chk_out("post_rst", 32'h00000001, 1'b1, 1'b0);

        // Randomized traffic, checked every cycle by the compare process.
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] s;
            s = 3'($urandom_range(0, 7));
            bus.in_valid = ($urandom_range(0, 4) != 0);
            bus.ImmSrc   = s;
            bus.ext      = 12'($urandom);
            bus.instr    = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                if (s == 3'd0 || s == 3'd5) bus.instr = 'x;
                else if (s <= 3'd4)         bus.ext   = 'x;
            end
            @(posedge clk);
            #1;
        end

        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
